// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scan controller.
package keypad_pkg;

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StPresent,
        StRelease
    } keypad_state_e;

    localparam logic [3:0] ROW_IDLE_INIT = 4'b1000;

    // Key-code layout: row index in [3:2], column index in [1:0].
    localparam int unsigned KEY_ROW_LSB = 2;
    localparam int unsigned KEY_COL_LSB = 0;

    function automatic logic [3:0] make_key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = '0;
        code[KEY_ROW_LSB +: 2] = row;
        code[KEY_COL_LSB +: 2] = col;
        return code;
    endfunction

    function automatic logic [1:0] lowest_col(input logic [3:0] cols);
        logic [1:0] idx;
        idx = '0;
        for (int i = 3; i >= 0; i--) begin
            if (cols[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_row_driver.sv
// One-hot row rotation with a per-row dwell counter; strobes the last dwell cycle of each row.
module keypad_row_driver
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic       clk_1,
    input  logic       rst,
    output logic [3:0] rows,
    output logic [1:0] row_idx,
    output logic       sample,
    output logic       frame_end
);

    localparam int unsigned CntW = $clog2(SCAN_DIV);
    localparam logic [CntW-1:0] CntLast = CntW'(SCAN_DIV - 1);

    logic [CntW-1:0] dwell_q, dwell_d;
    logic [1:0]      row_idx_q, row_idx_d;

    always_comb begin
        sample    = (dwell_q == CntLast);
        dwell_d   = sample ? '0 : dwell_q + CntW'(1);
        row_idx_d = sample ? row_idx_q + 2'd1 : row_idx_q;
        frame_end = sample && (row_idx_q == 2'd3);
    end

    always_ff @(posedge clk_1) begin
        if (rst) begin
            dwell_q   <= '0;
            row_idx_q <= 2'd0;
        end else begin
            dwell_q   <= dwell_d;
            row_idx_q <= row_idx_d;
        end
    end

    assign rows    = ROW_IDLE_INIT >> row_idx_q;
    assign row_idx = row_idx_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: frame-level debounce and one valid/ready emission per press.
// Define KEYPAD_REPEAT_EN to re-emit a held key every REPEAT_SCANS frames.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_SCANS   = 64
) (
    input  logic       clk_1,
    input  logic       rst,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic       key_valid,
    output logic [3:0] key_code,
    input  logic       key_ready,
    output logic       busy
);

    localparam int unsigned MatchW = $clog2(DEBOUNCE_SCANS + 1);

    logic [1:0] row_idx;
    logic       sample;
    logic       frame_end;

    keypad_row_driver #(
        .SCAN_DIV (SCAN_DIV)
    ) u_row_driver (
        .clk_1     (clk_1),
        .rst       (rst),
        .rows      (rows),
        .row_idx   (row_idx),
        .sample    (sample),
        .frame_end (frame_end)
    );

    keypad_state_e     state_q, state_d;
    logic [3:0]        cand_q, cand_d;
    logic [MatchW-1:0] match_q, match_d;
    logic              acc_hit_q, acc_hit_d;
    logic [3:0]        acc_code_q, acc_code_d;
    logic              row_hit;
    logic [3:0]        row_code;
    logic              frame_hit;
    logic [3:0]        frame_code;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned RepW = $clog2(REPEAT_SCANS + 1);
    logic [RepW-1:0] rep_q, rep_d;
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = (REPEAT_SCANS != 0);
`endif

    // Frame accumulator keeps the first hit of rows 0..2; row 3 is merged at frame end.
    always_comb begin
        row_hit    = |cols;
        row_code   = make_key_code(row_idx, lowest_col(cols));
        acc_hit_d  = acc_hit_q;
        acc_code_d = acc_code_q;
        if (sample && (row_idx == 2'd0 || !acc_hit_q)) begin
            acc_hit_d  = row_hit;
            acc_code_d = row_code;
        end
        frame_hit  = acc_hit_q || row_hit;
        frame_code = acc_hit_q ? acc_code_q : row_code;
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        match_d = match_q;
`ifdef KEYPAD_REPEAT_EN
        rep_d   = rep_q;
`endif
        unique case (state_q)
            StScan: begin
                if (frame_end && frame_hit) begin
                    cand_d  = frame_code;
                    match_d = MatchW'(1);
                    state_d = (DEBOUNCE_SCANS == 1) ? StPresent : StDebounce;
                end
            end
            StDebounce: begin
                if (frame_end) begin
                    if (frame_hit && frame_code == cand_q) begin
                        match_d = match_q + MatchW'(1);
                        if (match_d == MatchW'(DEBOUNCE_SCANS)) begin
                            state_d = StPresent;
                        end
                    end else begin
                        match_d = '0;
                        state_d = StScan;
                    end
                end
            end
            StPresent: begin
`ifdef KEYPAD_REPEAT_EN
                rep_d = '0;
`endif
                if (key_ready) begin
                    state_d = StRelease;
                end
            end
            StRelease: begin
                if (frame_end) begin
                    if (!frame_hit) begin
                        state_d = StScan;
`ifdef KEYPAD_REPEAT_EN
                        rep_d   = '0;
                    end else if (frame_code == cand_q) begin
                        if (rep_q + RepW'(1) == RepW'(REPEAT_SCANS)) begin
                            rep_d   = '0;
                            state_d = StPresent;
                        end else begin
                            rep_d = rep_q + RepW'(1);
                        end
                    end else begin
                        rep_d = '0;
`endif
                    end
                end
            end
            default: state_d = StScan;
        endcase
    end

    always_ff @(posedge clk_1) begin
        if (rst) begin
            state_q    <= StScan;
            cand_q     <= '0;
            match_q    <= '0;
            acc_hit_q  <= 1'b0;
            acc_code_q <= '0;
`ifdef KEYPAD_REPEAT_EN
            rep_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            match_q    <= match_d;
            acc_hit_q  <= acc_hit_d;
            acc_code_q <= acc_code_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q      <= rep_d;
`endif
        end
    end

    assign key_valid = (state_q == StPresent);
    assign key_code  = cand_q;
    assign busy      = (state_q != StScan);

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Scan controller for a 4x4 matrix keypad.
- Sequences the one-hot row drive, dwelling a programmable time on each row.
- Samples the column inputs and debounces a detected key.
- Delivers one 4-bit key code per press to downstream logic over a valid/ready handshake.
- Sits between the keypad pins and the input-decoding logic of the project.

Parameters:
SCAN_DIV, 1000, clk_1 cycles each row is driven before columns are sampled (min 2)
DEBOUNCE_SCANS, 4, consecutive full-frame matches required to accept a key (min 1)
REPEAT_SCANS, 64, frames between auto-repeat emissions (used only with KEYPAD_REPEAT_EN)

Ports:
clk_1  input  1  system clock; the only clock
rst  input  1  reset; synchronous, active-high
cols  input  4  column sense lines, active-high, pre-synchronised upstream
rows  output  4  one-hot row drive
key_valid  output  1  key_code is valid
key_code  output  4  {row_idx[1:0], col_idx[1:0]}
key_ready  input  1  consumer accepts key_code when key_valid && key_ready
busy  output  1  high while in any state other than SCAN

Behaviour:
- Reset (rst=1 at a clk_1 edge):
  - rows=4'b1000, row_idx=0, dwell counter=0.
  - key_valid=0, key_code=0, busy=0, state=SCAN.
  - Applies mid-operation from any state; a pending key is dropped.
- Row sweep:
  - Row order 1000 -> 0100 -> 0010 -> 0001 -> 1000; row_idx 0..3, wraps 3->0.
  - Each row is held exactly SCAN_DIV cycles.
  - cols is sampled on the last dwell cycle of each row, then the row advances on the next edge.
- Frame: 4 rows. Frame hit = first sampled (row, col) with any cols bit set.
  - Lowest row_idx wins, then lowest col index.
  - No hit in a frame = frame idle.
- FSM states: SCAN, DEBOUNCE, PRESENT, RELEASE.
  - SCAN: at end of a frame with a hit, latch candidate code and go to DEBOUNCE with match count=1.
    - If DEBOUNCE_SCANS=1, go directly to PRESENT instead.
  - DEBOUNCE: at each frame end:
    - Same code: count+1. When count reaches DEBOUNCE_SCANS, go to PRESENT.
    - Different code or idle frame: back to SCAN, count cleared.
  - PRESENT:
    - Entry cycle: key_valid=1, key_code=candidate.
    - key_valid and key_code are held stable until the handshake key_valid && key_ready.
    - The cycle after the handshake: key_valid=0, go to RELEASE.
    - If key_ready is already high on entry, key_valid is high for exactly 1 cycle.
  - RELEASE: wait for one idle frame, then go to SCAN. Any hit in a frame restarts the wait.
- Row sweeping continues in all states; rows is never all-zero or multi-hot.
- A key pressed while in PRESENT or RELEASE is never emitted. Exactly one emission per press.
- Counter widths: dwell counter uses $clog2(SCAN_DIV) bits; match and repeat counters are sized from their parameters; no overflow paths.

Optional Feature:
Macro KEYPAD_REPEAT_EN.
- Defined:
  - In RELEASE, if the same code is hit in REPEAT_SCANS consecutive frames, re-enter PRESENT and emit the code again.
  - The repeat counter clears on each emission, on a different code, and on an idle frame.
- Undefined: no repeat logic is synthesised; REPEAT_SCANS is ignored; one emission per press.

Decomposition:
- Shared package keypad_pkg holds:
  - the state enum (SCAN, DEBOUNCE, PRESENT, RELEASE);
  - ROW_IDLE_INIT = 4'b1000;
  - the key-code field layout (row in [3:2], col in [1:0]).
- One sub-module: keypad_row_driver.
  - Contains the dwell counter and the one-hot rotation.
  - Outputs rows, row_idx and a sample strobe; the FSM consumes the strobe.

Test Plan:
1. SCAN_DIV=4, DEBOUNCE_SCANS=2, no press -> rows rotates 1000,0100,0010,0001 every 4 cycles; key_valid stays 0 for 100 cycles.
2. Hold cols=4'b0010 only while rows=0100, key_ready=1 -> after 2 frames, one key_valid pulse with key_code=4'b0101; no second pulse while held.
3. Same press with key_ready=0 for 20 cycles -> key_valid=1, key_code=0101 stable for all 20 cycles; deasserts the cycle after key_ready rises.
4. Bounce: press present in frame 1, absent in frame 2, present in frames 3-4 -> exactly one emission, after frame 4.
5. Rows 0 and 2 both hit (cols=0001 on 1000, cols=1000 on 0010) -> key_code=4'b0000.
6. rst=1 while in PRESENT with key_valid=1 -> next cycle key_valid=0, rows=1000, busy=0; with KEYPAD_REPEAT_EN and REPEAT_SCANS=3, holding a key gives a re-emission every 3 frames.
